// File: rtl/fft_ctrl_pkg.sv
// Shared types and geometry for the FFT frame controller.
package fft_ctrl_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned BANKS      = 4;
    localparam int unsigned BANK_DEPTH = 512;
    localparam int unsigned N_POINTS   = BANKS * BANK_DEPTH;
    localparam int unsigned ADDR_W     = $clog2(BANK_DEPTH);
    localparam int unsigned IDX_W      = $clog2(N_POINTS);
    localparam int unsigned BANK_W     = $clog2(BANKS);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_RDY = 2'd2,
        READOUT  = 2'd3
    } state_t;

    // Top index bits pick the bank, the rest is the in-bank word address.
    function automatic logic [BANK_W-1:0] bank_of(input logic [IDX_W-1:0] k);
        return k[IDX_W-1 -: BANK_W];
    endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Small synchronous FIFO with occupancy count; head is shown combinationally.
module fft_out_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

    // Pointer, count and storage update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty FIFO presents zero so stale storage never leaks out.
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: loads 2048 ADC samples into four banks, launches the FFT,
// waits for completion and streams the real-part results out in order.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iADC_DATA,
    input  logic              iADC_VALID,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    input  logic              iFFT_RDY,
    output logic [ADDR_W-1:0] oADDR_RD_0,
    output logic [ADDR_W-1:0] oADDR_RD_1,
    output logic [ADDR_W-1:0] oADDR_RD_2,
    output logic [ADDR_W-1:0] oADDR_RD_3,
    input  logic [DATA_W-1:0] iDATA_RE_0,
    input  logic [DATA_W-1:0] iDATA_RE_1,
    input  logic [DATA_W-1:0] iDATA_RE_2,
    input  logic [DATA_W-1:0] iDATA_RE_3,
    output logic [DATA_W-1:0] oOUT_DATA,
    output logic              oOUT_VALID,
    input  logic              iOUT_READY,
    output logic              oBUSY,
    output logic              oERR,
    output logic [15:0]       oDROP_CNT
);

    localparam int unsigned      FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned      SUM_W      = CNT_W + 1;
    localparam int unsigned      TMO_W      = $clog2(TIMEOUT + 1);
    localparam int unsigned      DROP_W     = 16;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_POINTS - 1);

    state_t                       r_state;
    logic [IDX_W-1:0]             r_wr_idx;
    logic [IDX_W-1:0]             r_rd_idx;
    logic [IDX_W-1:0]             r_xfer;
    logic                         r_rd_done;
    logic                         r_rdy_q;
    logic [TMO_W-1:0]             r_tmo;
    logic [RD_LAT:0]              r_vld_pipe;
    logic [RD_LAT:0][BANK_W-1:0]  r_bank_pipe;
    logic [DATA_W-1:0]            r_data;
    logic [BANKS-1:0][ADDR_W-1:0] r_addr_wr;
    logic [BANKS-1:0][ADDR_W-1:0] r_addr_rd;
    logic [BANKS-1:0]             r_we;
    logic                         r_start;
    logic                         r_busy;
    logic                         r_err;
    logic [DROP_W-1:0]            r_drop;

    logic                         w_rdy_rise;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_issue;
    logic                         w_credit_ok;
    logic [CNT_W-1:0]             w_fifo_cnt;
    logic [CNT_W-1:0]             w_occ;
    logic [CNT_W-1:0]             w_inflight;
    logic [DATA_W-1:0]            w_fifo_data;
    logic                         w_fifo_valid;
    logic [DATA_W-1:0]            w_push_data;

    assign w_rdy_rise = iFFT_RDY & ~r_rdy_q;
    assign w_pop      = w_fifo_valid & iOUT_READY;
    assign w_push     = r_vld_pipe[RD_LAT];
    assign w_occ      = w_fifo_cnt - CNT_W'(w_pop);

    // Number of reads issued whose data has not yet reached the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i <= RD_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_vld_pipe[i]);
        end
    end

    // Issue only when the FIFO is guaranteed a free slot for the returning word.
    assign w_credit_ok = (SUM_W'(w_occ) + SUM_W'(w_inflight)) < SUM_W'(FIFO_DEPTH);
    assign w_issue     = (r_state == READOUT) & ~r_rd_done & w_credit_ok;

    // Route the returning bank's data using the delayed bank select.
    always_comb begin
        w_push_data = iDATA_RE_0;
        case (r_bank_pipe[RD_LAT])
            2'd1:    w_push_data = iDATA_RE_1;
            2'd2:    w_push_data = iDATA_RE_2;
            2'd3:    w_push_data = iDATA_RE_3;
            default: w_push_data = iDATA_RE_0;
        endcase
    end

    fft_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .i_clk   (iCLK),
        .i_rst   (iRESET),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    // Frame FSM with registered bank-write, launch, read-issue and status outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state     <= FILL;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_xfer      <= '0;
            r_rd_done   <= 1'b0;
            r_rdy_q     <= 1'b0;
            r_tmo       <= '0;
            r_vld_pipe  <= '0;
            r_bank_pipe <= '0;
            r_data      <= '0;
            r_addr_wr   <= '0;
            r_addr_rd   <= '0;
            r_we        <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_rdy_q    <= iFFT_RDY;
            r_we       <= '0;
            r_start    <= 1'b0;
            r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_issue};
            r_bank_pipe[0] <= bank_of(r_rd_idx);
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                r_bank_pipe[i] <= r_bank_pipe[i-1];
            end

            if (iADC_VALID && (r_state != FILL) && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end

            if (w_issue) begin
                r_addr_rd[bank_of(r_rd_idx)] <= r_rd_idx[ADDR_W-1:0];
                r_rd_idx <= r_rd_idx + IDX_W'(1);
                if (r_rd_idx == LAST_IDX) begin
                    r_rd_done <= 1'b1;
                end
            end

            case (r_state)
                FILL: begin
                    if (iADC_VALID) begin
                        r_we[bank_of(r_wr_idx)]      <= 1'b1;
                        r_addr_wr[bank_of(r_wr_idx)] <= r_wr_idx[ADDR_W-1:0];
                        r_data   <= iADC_DATA;
                        r_err    <= 1'b0;
                        r_wr_idx <= r_wr_idx + IDX_W'(1);
                        if (r_wr_idx == LAST_IDX) begin
                            r_state <= LAUNCH;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    r_start <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (w_rdy_rise) begin
                        r_rd_idx  <= '0;
                        r_rd_done <= 1'b0;
                        r_xfer    <= '0;
                        r_state   <= READOUT;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_err    <= 1'b1;
                        r_wr_idx <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= FILL;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                READOUT: begin
                    if (w_pop) begin
                        r_xfer <= r_xfer + IDX_W'(1);
                        if (r_xfer == LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_busy   <= 1'b0;
                            r_state  <= FILL;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign oDATA      = r_data;
    assign oADDR_WR_0 = r_addr_wr[0];
    assign oADDR_WR_1 = r_addr_wr[1];
    assign oADDR_WR_2 = r_addr_wr[2];
    assign oADDR_WR_3 = r_addr_wr[3];
    assign oWE_0      = r_we[0];
    assign oWE_1      = r_we[1];
    assign oWE_2      = r_we[2];
    assign oWE_3      = r_we[3];
    assign oSTART     = r_start;
    assign oADDR_RD_0 = r_addr_rd[0];
    assign oADDR_RD_1 = r_addr_rd[1];
    assign oADDR_RD_2 = r_addr_rd[2];
    assign oADDR_RD_3 = r_addr_rd[3];
    assign oOUT_DATA  = w_fifo_data;
    assign oOUT_VALID = w_fifo_valid;
    assign oBUSY      = r_busy;
    assign oERR       = r_err;
    assign oDROP_CNT  = r_drop;

endmodule
